// File: rtl/dffrs_init_seq.sv
// Preload sequencer for a bank of dffrs cells: pulses R/S low to force a pattern,
// lets the bank settle, then reads back Q and reports per-bit mismatches.
module dffrs_init_seq #(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] r_n,
  output logic [WIDTH-1:0] s_n,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_mask
);

  localparam int MAXC  = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] pat, pat_nxt;
  logic [WIDTH-1:0] r_n_nxt, s_n_nxt, mask_nxt;
  logic             busy_nxt, done_nxt, mis_nxt;

  // Reset holds the bank cleared (R pins low) and discards any preload in flight.
  always_ff @(posedge clk) begin
    if (!R) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pat           <= '0;
      r_n           <= '0;
      s_n           <= '1;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      mismatch_mask <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pat           <= pat_nxt;
      r_n           <= r_n_nxt;
      s_n           <= s_n_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      mismatch      <= mis_nxt;
      mismatch_mask <= mask_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    mask_nxt  = mismatch_mask;
    mis_nxt   = mismatch;
    done_nxt  = 1'b0;
    r_n_nxt   = '1;
    s_n_nxt   = '1;
    busy_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pat_nxt   = init_val;
          mask_nxt  = '0;
          mis_nxt   = 1'b0;
          cnt_nxt   = PULSE_LOAD;
          state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cnt == '0) begin
          if (SETTLE_CYCLES == 0) begin
            state_nxt = ST_CHECK;
          end else begin
            cnt_nxt   = SETTLE_LOAD;
            state_nxt = ST_SETTLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_CHECK: begin
        mask_nxt  = q_in ^ pat;
        mis_nxt   = |(q_in ^ pat);
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // R follows the pattern and S its complement, so one pin per bit is ever low.
    case (state_nxt)
      ST_ASSERT: begin
        r_n_nxt  = pat_nxt;
        s_n_nxt  = ~pat_nxt;
        busy_nxt = 1'b1;
      end
      ST_SETTLE, ST_CHECK: busy_nxt = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dffrs_init_seq.sv
// Randomized bench for dffrs_init_seq: expected waveforms are derived from the
// preload timeline (pulse, settle, check, done) by cycle arithmetic.
module tb_dffrs_init_seq;

  localparam int W = 8;
  localparam int P = 2;
  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, settle of one cycle
  logic         R, start;
  logic [W-1:0] init_val, q_in, r_n, s_n, mismatch_mask;
  logic         busy, done, mismatch;

  // Second instance with the settle phase bypassed
  logic         R0, start0;
  logic [W-1:0] init_val0, q_in0, r_n0, s_n0, mismatch_mask0;
  logic         busy0, done0, mismatch0;

  int total = 0;
  int bad   = 0;

  dffrs_init_seq #(.WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .R(R), .start(start), .init_val(init_val), .q_in(q_in),
    .r_n(r_n), .s_n(s_n), .busy(busy), .done(done),
    .mismatch(mismatch), .mismatch_mask(mismatch_mask)
  );

  dffrs_init_seq #(.WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .R(R0), .start(start0), .init_val(init_val0), .q_in(q_in0),
    .r_n(r_n0), .s_n(s_n0), .busy(busy0), .done(done0),
    .mismatch(mismatch0), .mismatch_mask(mismatch_mask0)
  );

  // A bank bit must never see R and S low together.
  always @(negedge clk) begin
    if (R === 1'b1 && (~r_n & ~s_n) !== '0) begin
      bad++;
      $display("[TB] FAIL rs_overlap got r_n=%h s_n=%h exp no common zero", r_n, s_n);
    end
    if (R0 === 1'b1 && (~r_n0 & ~s_n0) !== '0) begin
      bad++;
      $display("[TB] FAIL rs_overlap0 got r_n=%h s_n=%h exp no common zero", r_n0, s_n0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [26:0] obs, exp;
    R = 1'b0; start = 1'b0; init_val = '0; q_in = '0;
    tick; tick;
    obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
    exp = {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h exp=%h", obs, exp);
    end
    R = 1'b1;
    tick;
    obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
    exp = {8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release got=%h exp=%h", obs, exp);
    end
  endtask

  // One full preload: start accepted at edge 0, then every cycle through done
  // is compared against the timeline; optional start/init noise while busy.
  task automatic test_preload(input logic [W-1:0] p, input logic [W-1:0] qv,
                              input logic hold, input logic [W-1:0] junk, input string name);
    logic [26:0] obs, exp;
    logic [W-1:0] er, es, em;
    logic eb, ed, emis;
    start = 1'b1; init_val = p; q_in = W'($urandom);
    tick;
    for (int k = 1; k <= P + S + 2; k++) begin
      em = '0; emis = 1'b0; ed = 1'b0;
      if (k <= P) begin
        er = p; es = ~p; eb = 1'b1;
      end else if (k <= P + S + 1) begin
        er = '1; es = '1; eb = 1'b1;
      end else begin
        er = '1; es = '1; eb = 1'b0; ed = 1'b1;
        em = qv ^ p; emis = (qv != p);
      end
      obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
      exp = {er, es, eb, ed, emis, em};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL %s cycle%0d got=%h exp=%h", name, k, obs, exp);
      end
      if (k <= P + S + 1) begin
        start    = hold;
        init_val = hold ? junk : W'($urandom);
      end else begin
        start = 1'b0;
      end
      q_in = (k == P + S + 1) ? qv : W'($urandom);
      tick;
    end
    obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
    exp = {8'hFF, 8'hFF, 1'b0, 1'b0, (qv != p), qv ^ p};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s after_done got=%h exp=%h", name, obs, exp);
    end
  endtask

  task automatic test_nominal;
    test_preload(8'hA5, 8'hA5, 1'b0, 8'h00, "nominal");
  endtask

  task automatic test_mismatch;
    test_preload(8'hA5, 8'hA4, 1'b0, 8'h00, "mismatch");
    for (int i = 0; i < 3; i++) begin
      q_in = W'($urandom);
      tick;
      total++;
      if ({mismatch, mismatch_mask} !== {1'b1, 8'h01}) begin
        bad++;
        $display("[TB] FAIL mismatch_hold got=%b/%h exp=1/01", mismatch, mismatch_mask);
      end
    end
    // The next preload clears the flags from its first busy cycle on
    test_preload(8'h5A, 8'h5A, 1'b0, 8'h00, "mismatch_clear");
  endtask

  task automatic test_busy_ignore;
    test_preload(8'h3C, 8'h3C, 1'b1, 8'hFF, "busy_ignore");
  endtask

  task automatic test_reset_mid;
    logic [26:0] obs, exp;
    start = 1'b1; init_val = 8'h96; q_in = 8'h96;
    tick;
    start = 1'b0;
    tick;
    R = 1'b0;
    tick;
    obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
    exp = {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL reset_mid got=%h exp=%h", obs, exp);
    end
    R = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      obs = {r_n, s_n, busy, done, mismatch, mismatch_mask};
      exp = {8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL reset_mid_idle%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] p, qv, junk;
    logic hold;
    for (int n = 0; n < 20; n++) begin
      p    = W'($urandom);
      qv   = ($urandom_range(0, 1) == 0) ? p : W'($urandom);
      hold = 1'($urandom_range(0, 1));
      junk = W'($urandom);
      test_preload(p, qv, hold, junk, "random");
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick;
    end
  endtask

  // Settle bypassed and start held high: a preload repeats every P+2 cycles.
  task automatic test_back_to_back;
    logic [26:0] obs, exp;
    int m;
    R0 = 1'b0; start0 = 1'b0; init_val0 = '0; q_in0 = 8'h0F;
    tick;
    R0 = 1'b1;
    tick;
    start0 = 1'b1; init_val0 = 8'h0F;
    tick;
    for (int k = 1; k <= 12; k++) begin
      m = ((k - 1) % (P + 2)) + 1;
      if (m <= P)
        exp = {8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00};
      else if (m == P + 1)
        exp = {8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00};
      else
        exp = {8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00};
      obs = {r_n0, s_n0, busy0, done0, mismatch0, mismatch_mask0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL back_to_back cycle%0d got=%h exp=%h", k, obs, exp);
      end
      tick;
    end
    start0 = 1'b0;
  endtask

  initial begin
    R0 = 1'b0; start0 = 1'b0; init_val0 = '0; q_in0 = '0;
    test_reset;
    test_nominal;
    test_mismatch;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    test_back_to_back;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dffrs_init_seq.md
Name: dffrs_init_seq

Overview:
- Preload sequencer for a bank of WIDTH dffrs cells, which have asynchronous active-low R (clear, dominant) and S (set).
- On a start request it drives each cell's R or S pin low for a programmable pulse to force a latched init pattern into the bank, releases, waits a settle time, then reads back the cell Q outputs and flags mismatches.
- Sits between the configuration/bring-up logic and the flop bank; owns every R/S pin of that bank.

Parameters:
- WIDTH, 8, number of dffrs cells controlled.
- PULSE_CYCLES, 2, cycles the R/S pins are held low per preload; legal range >= 1.
- SETTLE_CYCLES, 1, idle cycles after release before readback; legal range >= 0, where 0 skips SETTLE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-low.
- start  input  1  request a preload; sampled only in IDLE.
- init_val  input  WIDTH  pattern to preload; captured on accepted start.
- q_in  input  WIDTH  Q outputs of the bank, for readback.
- r_n  output  WIDTH  drives bank R pins, active-low.
- s_n  output  WIDTH  drives bank S pins, active-low.
- busy  output  1  high while a preload is in progress.
- done  output  1  one-cycle pulse when readback is complete.
- mismatch  output  1  OR of mismatch_mask; valid from the done cycle.
- mismatch_mask  output  WIDTH  per-bit q_in XOR latched pattern.

Behaviour:
- All outputs are registered.
- Reset values (R low at an edge):
  - state IDLE, r_n all 0 (bank held cleared), s_n all 1.
  - busy 0, done 0, mismatch 0, mismatch_mask 0, latched pattern 0.
- First edge with R high: IDLE, r_n all 1 (bank released).
- Reset is synchronous: a mid-operation reset aborts at the next edge with the reset values above. No partial preload state survives.
- States: IDLE -> ASSERT -> SETTLE -> CHECK -> IDLE.
- IDLE:
  - r_n = s_n = all 1, busy 0.
  - start=1 at edge: latch init_val as pat, clear mismatch/mismatch_mask, load the cycle counter, go to ASSERT.
- ASSERT, exactly PULSE_CYCLES cycles:
  - r_n = pat, so 0-bits are cleared.
  - s_n = ~pat, so 1-bits are set.
  - busy 1.
  - Invariant: for each bit, r_n and s_n are never both 0.
- SETTLE, exactly SETTLE_CYCLES cycles (bypassed if 0):
  - r_n = s_n = all 1, busy 1.
- CHECK, one cycle:
  - r_n = s_n = all 1, busy 1.
  - At the end edge: mismatch_mask <= q_in ^ pat, mismatch <= |(q_in ^ pat), done <= 1, go to IDLE.
- done is high for exactly one cycle: the first IDLE cycle after CHECK.
- mismatch/mismatch_mask hold until the next accepted start or reset.
- Latency, with start accepted at edge 0:
  - busy high for cycles 1 .. PULSE_CYCLES+SETTLE_CYCLES+1.
  - done in cycle PULSE_CYCLES+SETTLE_CYCLES+2.
- Handshake rules:
  - start while busy is ignored; no queueing; init_val changes have no effect.
  - start in the done cycle is accepted (back-to-back).
  - start held high continuously triggers repeated preloads, one per IDLE visit.
- Counter:
  - Single down-counter, width clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1).
  - Reloaded on each state entry; no wrap; transition when it reaches the terminal count.
- q_in is sampled only in CHECK; changes at any other time are ignored.

Test Plan:
- Nominal (WIDTH=8, PULSE=2, SETTLE=1): R high, start with init_val=0xA5 at edge 0, q_in=0xA5.
  - Required: cycles 1-2 r_n=0xA5, s_n=0x5A, busy=1.
  - Cycle 3 r_n=s_n=0xFF; cycle 4 CHECK.
  - Cycle 5 done=1, busy=0, mismatch=0, mask=0x00.
- Mismatch: same, but q_in=0xA4 in CHECK.
  - Required: done cycle mismatch=1, mask=0x01.
  - Both hold through idle cycles; both clear on the next accepted start.
- Busy-ignore: start with 0x3C, then start with 0xFF at cycles 1-3.
  - Required: r_n=0x3C, s_n=0xC3 throughout ASSERT.
  - Exactly one done, at cycle 5.
- Reset mid-operation: R low at cycle 2 (in ASSERT).
  - Required: next cycle r_n=0x00, s_n=0xFF, busy=0, done=0.
  - After R high, IDLE with r_n=0xFF; no done ever emitted.
- SETTLE_CYCLES=0 with start held high, init_val=0x0F.
  - Required: ASSERT 2 cycles, CHECK, done in cycle 4.
  - Second preload accepted at the done-cycle edge; ASSERT again in cycles 5-6.
  - Per-bit r_n & s_n never both 0 (assertion active throughout).
